// File: rtl/pqsdn_cam_wr_ctrl.sv
// Write-side table manager for the pqsdn CAM: slot allocation, delete, and zero sweep on reset/flush.
// Optional macro PQSDN_CAM_WR_ZERO_ON_DEL_EN makes a successful delete also zero the CAM entry.
module pqsdn_cam_wr_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int EN_W   = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_op_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  output logic                rsp_valid_o,
  output logic [ADDR_W-1:0]   rsp_addr_o,
  output logic [1:0]          rsp_status_o,
  output logic                en_a_o,
  output logic [EN_W-1:0]     wren_a_o,
  output logic [ADDR_W-1:0]   wraddr_a_o,
  output logic [DATA_W-1:0]   wrdata_a_o,
  output logic [ADDR_W:0]     occupancy_o,
  output logic                busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_FULL      = 2'b01;
  localparam logic [1:0] ST_NOT_VALID = 2'b10;
  localparam logic [1:0] ST_KEY_RSVD  = 2'b11;

  typedef enum logic [1:0] {CLEAR, IDLE, EXEC, RESP} state_e;

  state_e              state_q;
  logic [DEPTH-1:0]    bitmap_q;
  logic [ADDR_W-1:0]   sweepCnt_q;
  logic                sweepDone_q;
  logic [1:0]          pendStatus_q;
  logic [ADDR_W-1:0]   pendAddr_q;
  logic                pendSet_q;
  logic                pendClr_q;
  logic                reqReady_q;
  logic                rspValid_q;
  logic [ADDR_W-1:0]   rspAddr_q;
  logic [1:0]          rspStatus_q;
  logic                enA_q;
  logic [EN_W-1:0]     wrenA_q;
  logic [ADDR_W-1:0]   wraddrA_q;
  logic [DATA_W-1:0]   wrdataA_q;
  logic [ADDR_W:0]     occupancy_q;
  logic                busy_q;

  logic [ADDR_W-1:0]   freeSlot;
  logic                tableFull;
  logic [1:0]          decStatus_d;
  logic [ADDR_W-1:0]   decAddr_d;
  logic                decWrite_d;
  logic [DATA_W-1:0]   decData_d;
  logic                decSet_d;
  logic                decClr_d;

  // Lowest-index free slot: scanning downward lets the smallest index win.
  always_comb begin
    freeSlot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) freeSlot = ADDR_W'(i);
    end
    tableFull = &bitmap_q;
  end

  // The request is resolved on the accept edge so the CAM write is registered into the EXEC cycle.
  always_comb begin
    decStatus_d = ST_OK;
    decAddr_d   = req_addr_i;
    decWrite_d  = 1'b0;
    decData_d   = '0;
    decSet_d    = 1'b0;
    decClr_d    = 1'b0;
    if (!req_op_i) begin
      decAddr_d = '0;
      if (req_data_i == '0) begin
        decStatus_d = ST_KEY_RSVD;
      end else if (tableFull) begin
        decStatus_d = ST_FULL;
      end else begin
        decAddr_d  = freeSlot;
        decWrite_d = 1'b1;
        decData_d  = req_data_i;
        decSet_d   = 1'b1;
      end
    end else if (!bitmap_q[req_addr_i]) begin
      decStatus_d = ST_NOT_VALID;
    end else begin
      decClr_d = 1'b1;
`ifdef PQSDN_CAM_WR_ZERO_ON_DEL_EN
      decWrite_d = 1'b1;
`else
      decWrite_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      bitmap_q     <= '0;
      sweepCnt_q   <= '0;
      sweepDone_q  <= 1'b0;
      pendStatus_q <= ST_OK;
      pendAddr_q   <= '0;
      pendSet_q    <= 1'b0;
      pendClr_q    <= 1'b0;
      reqReady_q   <= 1'b0;
      rspValid_q   <= 1'b0;
      rspAddr_q    <= '0;
      rspStatus_q  <= ST_OK;
      enA_q        <= 1'b0;
      wrenA_q      <= '0;
      wraddrA_q    <= '0;
      wrdataA_q    <= '0;
      occupancy_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (!sweepDone_q) begin
            enA_q     <= 1'b1;
            wrenA_q   <= '1;
            wrdataA_q <= '0;
            wraddrA_q <= sweepCnt_q;
            busy_q    <= 1'b1;
            if (sweepCnt_q == ADDR_W'(DEPTH - 1)) sweepDone_q <= 1'b1;
            else sweepCnt_q <= sweepCnt_q + ADDR_W'(1);
          end else begin
            enA_q       <= 1'b0;
            wrenA_q     <= '0;
            wraddrA_q   <= '0;
            busy_q      <= 1'b0;
            sweepDone_q <= 1'b0;
            sweepCnt_q  <= '0;
            reqReady_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        IDLE: begin
          if (flush_i) begin
            bitmap_q    <= '0;
            occupancy_q <= '0;
            sweepCnt_q  <= '0;
            sweepDone_q <= 1'b0;
            reqReady_q  <= 1'b0;
            state_q     <= CLEAR;
          end else if (req_valid_i && reqReady_q) begin
            reqReady_q   <= 1'b0;
            enA_q        <= decWrite_d;
            wrenA_q      <= decWrite_d ? '1 : '0;
            wraddrA_q    <= decWrite_d ? decAddr_d : '0;
            wrdataA_q    <= decData_d;
            pendStatus_q <= decStatus_d;
            pendAddr_q   <= decAddr_d;
            pendSet_q    <= decSet_d;
            pendClr_q    <= decClr_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          enA_q     <= 1'b0;
          wrenA_q   <= '0;
          wraddrA_q <= '0;
          wrdataA_q <= '0;
          if (pendSet_q) begin
            bitmap_q[pendAddr_q] <= 1'b1;
            occupancy_q          <= occupancy_q + (ADDR_W + 1)'(1);
          end else if (pendClr_q) begin
            bitmap_q[pendAddr_q] <= 1'b0;
            occupancy_q          <= occupancy_q - (ADDR_W + 1)'(1);
          end
          rspValid_q  <= 1'b1;
          rspAddr_q   <= pendAddr_q;
          rspStatus_q <= pendStatus_q;
          state_q     <= RESP;
        end
        RESP: begin
          rspValid_q <= 1'b0;
          reqReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign req_ready_o  = reqReady_q;
  assign rsp_valid_o  = rspValid_q;
  assign rsp_addr_o   = rspAddr_q;
  assign rsp_status_o = rspStatus_q;
  assign en_a_o       = enA_q;
  assign wren_a_o     = wrenA_q;
  assign wraddr_a_o   = wraddrA_q;
  assign wrdata_a_o   = wrdataA_q;
  assign occupancy_o  = occupancy_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pqsdn_cam_wr_ctrl.sv
// Self-checking bench for pqsdn_cam_wr_ctrl: directed vector table, fill/full, random ops vs a slot model,
// flush and mid-operation reset sequences. Honours PQSDN_CAM_WR_ZERO_ON_DEL_EN if defined.
module tb_pqsdn_cam_wr_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int EW    = DW / 8;
  localparam int DEPTH = 1 << AW;

`ifdef PQSDN_CAM_WR_ZERO_ON_DEL_EN
  localparam bit DEL_WRITES = 1'b1;
`else
  localparam bit DEL_WRITES = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_op_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic          rsp_valid_o;
  logic [AW-1:0] rsp_addr_o;
  logic [1:0]    rsp_status_o;
  logic          en_a_o;
  logic [EW-1:0] wren_a_o;
  logic [AW-1:0] wraddr_a_o;
  logic [DW-1:0] wrdata_a_o;
  logic [AW:0]   occupancy_o;
  logic          busy_o;

  pqsdn_cam_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_addr_o(rsp_addr_o), .rsp_status_o(rsp_status_o),
    .en_a_o(en_a_o), .wren_a_o(wren_a_o), .wraddr_a_o(wraddr_a_o), .wrdata_a_o(wrdata_a_o),
    .occupancy_o(occupancy_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit refValid[DEPTH];

  typedef struct {
    bit          op;
    logic [5:0]  addr;
    logic [63:0] data;
    logic [1:0]  st;
    logic [5:0]  ra;
    bit          wr;
    logic [6:0]  occ;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int refOcc();
    int n = 0;
    foreach (refValid[i]) if (refValid[i]) n++;
    return n;
  endfunction

  task automatic refClear();
    foreach (refValid[i]) refValid[i] = 1'b0;
  endtask

  // Slot-level model: occupied set, first free slot, reserved key 0.
  task automatic refStep(input bit op, input logic [5:0] a, input logic [63:0] d,
                         output logic [1:0] st, output logic [5:0] ra, output bit wr,
                         output logic [5:0] wa, output logic [63:0] wd, output bit addrKnown);
    int slot;
    slot = -1;
    wr = 1'b0; wa = '0; wd = '0; ra = '0; addrKnown = 1'b1; st = 2'b00;
    if (!op) begin
      if (d == 64'd0) begin
        st = 2'b11;
        addrKnown = 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) if (!refValid[i] && slot < 0) slot = i;
        if (slot < 0) begin
          st = 2'b01;
        end else begin
          refValid[slot] = 1'b1;
          ra = 6'(slot);
          wr = 1'b1; wa = 6'(slot); wd = d;
        end
      end
    end else begin
      ra = a;
      if (!refValid[a]) st = 2'b10;
      else begin
        refValid[a] = 1'b0;
        wr = DEL_WRITES; wa = a; wd = '0;
      end
    end
  endtask

  // Handshake one request and observe the write cycle, response cycle and ready recovery.
  task automatic applyStimulus(input bit op, input logic [5:0] a, input logic [63:0] d,
                               output bit oWr, output logic [5:0] oWa, output logic [63:0] oWd,
                               output logic [7:0] oWb, output logic [1:0] oSt,
                               output logic [5:0] oRa, output logic [6:0] oOcc);
    int waitCnt = 0;
    @(negedge clk);
    while (!req_ready_o && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("ready wait", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_data_i = d;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = 6'($urandom);
    req_data_i  = {$urandom, $urandom};
    @(negedge clk);
    oWr = en_a_o; oWa = wraddr_a_o; oWd = wrdata_a_o; oWb = wren_a_o;
    checkOutput("rsp early", 64'(rsp_valid_o), 64'd0);
    checkOutput("ready in exec", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    checkOutput("rsp strobe", 64'(rsp_valid_o), 64'd1);
    checkOutput("write in resp", 64'(en_a_o), 64'd0);
    oSt = rsp_status_o; oRa = rsp_addr_o; oOcc = occupancy_o;
    @(negedge clk);
    checkOutput("rsp one cycle", 64'(rsp_valid_o), 64'd0);
    checkOutput("ready back", 64'(req_ready_o), 64'd1);
  endtask

  task automatic runReq(input bit op, input logic [5:0] a, input logic [63:0] d,
                        output logic [1:0] oSt, output logic [5:0] oRa, output bit oWr,
                        output logic [6:0] oOcc);
    logic [5:0] oWa, eRa, eWa;
    logic [63:0] oWd, eWd;
    logic [7:0] oWb;
    logic [1:0] eSt;
    bit eWr, known;
    applyStimulus(op, a, d, oWr, oWa, oWd, oWb, oSt, oRa, oOcc);
    refStep(op, a, d, eSt, eRa, eWr, eWa, eWd, known);
    checkOutput("status", 64'(oSt), 64'(eSt));
    if (known) checkOutput("rsp addr", 64'(oRa), 64'(eRa));
    checkOutput("write en", 64'(oWr), 64'(eWr));
    if (eWr) begin
      checkOutput("write addr", 64'(oWa), 64'(eWa));
      checkOutput("write data", oWd, eWd);
      checkOutput("write be", 64'(oWb), 64'hFF);
    end
    checkOutput("occupancy", 64'(oOcc), 64'(refOcc()));
  endtask

  // Follow a full clear sweep until ready returns.
  task automatic observeSweep();
    int idx = 0, busyN = 0, rspN = 0, cyc = 0;
    @(negedge clk);
    while (!req_ready_o && cyc < 400) begin
      if (en_a_o) begin
        checkOutput("sweep addr", 64'(wraddr_a_o), 64'(idx));
        checkOutput("sweep data", wrdata_a_o, 64'd0);
        checkOutput("sweep be", 64'(wren_a_o), 64'hFF);
        idx++;
      end
      if (busy_o) busyN++;
      if (rsp_valid_o) rspN++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("sweep ready", 64'(req_ready_o), 64'd1);
    checkOutput("sweep writes", 64'(idx), 64'(DEPTH));
    checkOutput("sweep busy", 64'(busyN), 64'(DEPTH));
    checkOutput("sweep no rsp", 64'(rspN), 64'd0);
    checkOutput("sweep occ", 64'(occupancy_o), 64'd0);
    checkOutput("sweep busy low", 64'(busy_o), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    checkOutput({tag, " rsp_addr"}, 64'(rsp_addr_o), 64'd0);
    checkOutput({tag, " rsp_status"}, 64'(rsp_status_o), 64'd0);
    checkOutput({tag, " en"}, 64'(en_a_o), 64'd0);
    checkOutput({tag, " wren"}, 64'(wren_a_o), 64'd0);
    checkOutput({tag, " wraddr"}, 64'(wraddr_a_o), 64'd0);
    checkOutput({tag, " wrdata"}, wrdata_a_o, 64'd0);
    checkOutput({tag, " occ"}, 64'(occupancy_o), 64'd0);
    checkOutput({tag, " ready"}, 64'(req_ready_o), 64'd0);
  endtask

  initial begin
    logic [1:0] st;
    logic [5:0] ra;
    logic [6:0] occ;
    logic [63:0] d;
    bit wr;
    int waitCnt;

    vecs[0] = '{1'b0, 6'd0, 64'h11, 2'b00, 6'd0, 1'b1,       7'd1};
    vecs[1] = '{1'b0, 6'd0, 64'h22, 2'b00, 6'd1, 1'b1,       7'd2};
    vecs[2] = '{1'b0, 6'd0, 64'h33, 2'b00, 6'd2, 1'b1,       7'd3};
    vecs[3] = '{1'b1, 6'd1, 64'h0,  2'b00, 6'd1, DEL_WRITES, 7'd2};
    vecs[4] = '{1'b0, 6'd0, 64'h44, 2'b00, 6'd1, 1'b1,       7'd3};
    vecs[5] = '{1'b1, 6'd5, 64'h0,  2'b10, 6'd5, 1'b0,       7'd3};
    vecs[6] = '{1'b0, 6'd0, 64'h0,  2'b11, 6'd0, 1'b0,       7'd3};

    refClear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    observeSweep();

    for (int i = 0; i < 7; i++) begin
      runReq(vecs[i].op, vecs[i].addr, vecs[i].data, st, ra, wr, occ);
      checkOutput("vec status", 64'(st), 64'(vecs[i].st));
      if (vecs[i].st != 2'b11) checkOutput("vec addr", 64'(ra), 64'(vecs[i].ra));
      checkOutput("vec write", 64'(wr), 64'(vecs[i].wr));
      checkOutput("vec occ", 64'(occ), 64'(vecs[i].occ));
    end

    for (int k = 0; k < 200 && refOcc() < DEPTH; k++)
      runReq(1'b0, 6'd0, 64'h1000 + 64'(k), st, ra, wr, occ);
    runReq(1'b0, 6'd0, 64'hDEAD, st, ra, wr, occ);
    checkOutput("full status", 64'(st), 64'h1);
    checkOutput("full addr", 64'(ra), 64'd0);
    checkOutput("full write", 64'(wr), 64'd0);
    checkOutput("full occ", 64'(occ), 64'(DEPTH));
    runReq(1'b0, 6'd0, 64'd0, st, ra, wr, occ);
    checkOutput("rsvd when full", 64'(st), 64'h3);

    for (int k = 0; k < 150; k++) begin
      d = ($urandom_range(0, 9) == 0) ? 64'd0 : {$urandom, $urandom};
      runReq(1'($urandom_range(0, 1)), 6'($urandom_range(0, DEPTH - 1)), d, st, ra, wr, occ);
    end

    // flush beats a simultaneous request
    waitCnt = 0;
    @(negedge clk);
    while (!req_ready_o && waitCnt < 300) begin @(negedge clk); waitCnt++; end
    checkOutput("flush ready wait", 64'(req_ready_o), 64'd1);
    flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 1'b0; req_data_i = 64'hABC;
    @(posedge clk);
    #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    observeSweep();
    refClear();
    runReq(1'b0, 6'd0, 64'h77, st, ra, wr, occ);
    checkOutput("post flush addr", 64'(ra), 64'd0);
    checkOutput("post flush occ", 64'(occ), 64'd1);

    // reset pulse while an insert sits in EXEC
    waitCnt = 0;
    @(negedge clk);
    while (!req_ready_o && waitCnt < 300) begin @(negedge clk); waitCnt++; end
    checkOutput("rst ready wait", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_op_i = 1'b0; req_data_i = 64'h55;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    observeSweep();
    refClear();
    runReq(1'b0, 6'd0, 64'h99, st, ra, wr, occ);
    checkOutput("post reset addr", 64'(ra), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pqsdn_cam_wr_ctrl.md
Name: pqsdn_cam_wr_ctrl

Overview:
Write-side table manager for the pqsdn CAM.
- Accepts insert and delete requests from the control plane through a valid/ready handshake.
- Keeps a valid bitmap of occupied slots and allocates the lowest free address on insert.
- Drives the CAM write port (en/byte-enable/addr/data) and returns one response per request with the address and a status code.
- After reset, and on flush, sweeps the whole table writing zeros so the search side never matches stale entries.

Parameters:
DATA_W, 64, CAM key width in bits; must be a multiple of 8.
ADDR_W, 6, CAM address width; table depth is 2**ADDR_W.
EN_W, DATA_W/8, number of byte enables on the CAM write port.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  one-cycle pulse; sampled only in IDLE; clears the whole table
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready; high only in IDLE
req_op_i  in  1  0 = insert, 1 = delete
req_addr_i  in  ADDR_W  delete address (ignored for insert)
req_data_i  in  DATA_W  insert key (ignored for delete)
rsp_valid_o  out  1  one-cycle response strobe; no backpressure
rsp_addr_o  out  ADDR_W  allocated address (insert) or echoed address (delete)
rsp_status_o  out  2  00 OK, 01 FULL, 10 NOT_VALID, 11 KEY_RSVD
en_a_o  out  1  CAM write enable
wren_a_o  out  EN_W  CAM byte enables
wraddr_a_o  out  ADDR_W  CAM write address
wrdata_a_o  out  DATA_W  CAM write data
occupancy_o  out  ADDR_W+1  number of valid entries
busy_o  out  1  high in CLEAR state

Behaviour:
Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n, sampled on the rising edge.

Reset values and registering:
- All outputs are registered.
- On reset: rsp_valid_o=0, rsp_addr_o=0, rsp_status_o=0, en_a_o=0, wren_a_o=0, wraddr_a_o=0, wrdata_a_o=0, occupancy_o=0, req_ready_o=0.
- On reset the bitmap is all-zero and the FSM goes to CLEAR.

FSM states: CLEAR, IDLE, EXEC, RESP.

CLEAR:
- Sweep counter runs 0..2**ADDR_W-1, one address per cycle.
- Each cycle drives en_a_o=1, wren_a_o=all ones, wrdata_a_o=0, wraddr_a_o=counter.
- busy_o=1 and req_ready_o=0 throughout.
- After the last address, go to IDLE. CLEAR lasts exactly 2**ADDR_W cycles.

IDLE:
- req_ready_o=1; en_a_o=0.
- If flush_i=1: clear the bitmap, set occupancy to 0, enter CLEAR. flush_i has priority over a same-cycle request; that request is not accepted (ready falls next cycle).
- Otherwise, on req_valid_i & req_ready_o: latch op/addr/data and go to EXEC.

EXEC (one cycle):
- Insert, key == 0: status KEY_RSVD, no write. Zero marks an empty slot, so key 0 is reserved.
- Insert, bitmap all ones: status FULL, no write, rsp_addr_o=0.
- Insert, otherwise: take the lowest-index zero bit of the bitmap. Drive en_a_o=1, wren_a_o=all ones, wraddr=slot, wrdata=key. Set the bitmap bit, occupancy+1, status OK.
- Delete, bit clear: status NOT_VALID, no write.
- Delete, bit set: clear the bit, occupancy-1, status OK, write per the optional feature below.

RESP:
- rsp_valid_o=1 for exactly one cycle, then return to IDLE.

Timing and ordering:
- Request accepted at edge T: CAM write port is active in cycle T+1, rsp_valid_o in cycle T+2, req_ready_o high again in cycle T+3.
- Throughput: one request per 3 cycles.
- Duplicate keys are not detected; software owns uniqueness.
- occupancy_o never exceeds 2**ADDR_W and never underflows.

Reset mid-operation: in any state, returns to CLEAR with all outputs at reset values. An in-flight request is dropped with no response.

Optional Feature:
Macro PQSDN_CAM_WR_ZERO_ON_DEL_EN.
- Defined: a successful delete also writes all-zero data with all byte enables at the deleted address in EXEC, so the search side stops matching immediately.
- Not defined: a successful delete only clears the bitmap bit; en_a_o stays 0. The stale key remains searchable until the slot is reallocated or flushed.
- All other behaviour is identical.

Test Plan:
1. Reset with ADDR_W=6 -> 64 CLEAR writes to addresses 0..63 with data 0; busy_o high for 64 cycles; req_ready_o rises on cycle 65; occupancy_o=0.
2. Insert keys 0x11, 0x22, 0x33 -> CAM writes at 0, 1, 2; responses OK with rsp_addr_o 0, 1, 2; occupancy_o=3; each write 1 cycle and response 2 cycles after acceptance.
3. Delete addr 1, then insert 0x44 -> delete OK; insert allocates addr 1; delete of addr 5 returns NOT_VALID with no write; write on delete present only with PQSDN_CAM_WR_ZERO_ON_DEL_EN.
4. Fill all 64 slots, then a 65th insert -> FULL, rsp_addr_o=0, no CAM write, occupancy_o=64; insert key 0 at any time -> KEY_RSVD.
5. flush_i asserted together with req_valid_i in IDLE -> request not accepted; 64-cycle CLEAR; occupancy_o=0; the request accepted after CLEAR is allocated addr 0.
6. rst_n low for one cycle during EXEC of an insert -> no rsp_valid_o; outputs at reset values; CLEAR restarts at address 0.
